// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration request controller: FSM encoding,
// frame-word field positions and the expected frame length.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } cfg_state_e;

  localparam logic [4:0] WORD_CNT_TARGET = 5'd16;
  localparam logic [4:0] WORD_CNT_MAX    = 5'd31;
  localparam int         EOF_BIT         = 8;
  localparam int         ERR_BIT         = 9;

  function automatic logic is_busy(input cfg_state_e s);
    return (s == ST_REQ) || (s == ST_WAIT) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/cfg_tmo_cnt.sv
// Frame timeout counter: counts enabled cycles and raises a registered
// terminal-count flag the cycle after the count reaches TIMEOUT_CYC-1.
module cfg_tmo_cnt #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [15:0] r_cnt;
  logic        r_tc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else if (i_en) begin
      if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      r_tc <= (r_cnt == TIMEOUT_CYC - 16'd1);
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign o_tc = r_tc;

endmodule

// File: rtl/cfg_req_ctrl.sv
// Requests configuration frames from the link master, validates each frame
// and retries up to MAX_RETRY times before declaring failure.
module cfg_req_ctrl
  import cfg_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter logic [2:0]  MAX_RETRY   = 3'd5,
  parameter logic [2:0]  CHECK_DLY   = 3'd4
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        cfg_start,
  input  logic        slink_cfg_dval,
  input  logic [9:0]  slink_cfg_data,
  input  logic [31:0] cfg_md_id,
  input  logic [7:0]  cfg_com_mode,
  output logic        cfg_req,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_req_fail,
  output logic [2:0]  cfg_retry_cnt,
  output cfg_state_e  dbg_state
);

  // slink_cfg_dval is valid-only with no backpressure: a word is consumed on
  // every cycle dval is high while in WAIT and silently dropped in any other state.
  cfg_state_e r_state, w_next;
  logic [4:0] r_word_cnt;
  logic       r_err;
  logic [2:0] r_chk;
  logic [2:0] r_retry;
  logic       r_req, r_busy, r_done, r_fail;
  logic       w_req_d, w_busy_d, w_done_d, w_fail_d;
  logic       w_tc, w_eof, w_word, w_chk_end, w_frame_ok;
  logic       w_retry_dec, w_retry_take, w_restart;
  logic       w_unused;

  assign w_eof      = slink_cfg_dval && slink_cfg_data[EOF_BIT];
  assign w_word     = slink_cfg_dval && !slink_cfg_data[EOF_BIT];
  assign w_chk_end  = (r_chk == CHECK_DLY - 3'd1);
  assign w_frame_ok = (r_word_cnt == WORD_CNT_TARGET) && !r_err &&
                      (cfg_md_id != 32'd0) && (cfg_com_mode != 8'd0);
  assign w_retry_dec = ((r_state == ST_WAIT) && !w_eof && w_tc) ||
                       ((r_state == ST_CHECK) && w_chk_end && !w_frame_ok);
  assign w_retry_take = w_retry_dec && (r_retry != MAX_RETRY);
  assign w_restart = cfg_start &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL));
  assign w_unused  = ^slink_cfg_data[7:0];

  cfg_tmo_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .i_clk (clk_sys),
    .i_rst (rst_sys),
    .i_clr (r_state == ST_REQ),
    .i_en  ((r_state == ST_WAIT) && !w_eof),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk_sys) begin
    if (rst_sys) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (cfg_start) w_next = ST_REQ;
      ST_REQ:   w_next = ST_WAIT;
      ST_WAIT: begin
        // An end marker in the timeout cycle takes precedence over the retry.
        if (w_eof)             w_next = ST_CHECK;
        else if (w_tc)         w_next = w_retry_take ? ST_REQ : ST_FAIL;
      end
      ST_CHECK: begin
        if (w_chk_end) begin
          if (w_frame_ok)      w_next = ST_DONE;
          else                 w_next = w_retry_take ? ST_REQ : ST_FAIL;
        end
      end
      ST_DONE, ST_FAIL: if (cfg_start) w_next = ST_REQ;
      default:  w_next = ST_IDLE;
    endcase
  end

  // cfg_req trails the REQ state by one cycle so start-to-request latency is two.
  always_comb begin
    w_req_d  = (r_state == ST_REQ);
    w_busy_d = is_busy(w_next);
    w_done_d = (w_next == ST_DONE);
    w_fail_d = (w_next == ST_FAIL);
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_req  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_req  <= w_req_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      r_fail <= w_fail_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_word_cnt <= '0;
      r_err      <= 1'b0;
      r_chk      <= '0;
      r_retry    <= '0;
    end else begin
      r_chk <= (r_state == ST_CHECK) ? r_chk + 3'd1 : 3'd0;
      if (w_restart)         r_retry <= '0;
      else if (w_retry_take) r_retry <= r_retry + 3'd1;
      if (r_state == ST_REQ) begin
        r_word_cnt <= '0;
        r_err      <= 1'b0;
      end else if (r_state == ST_WAIT) begin
        if (w_word && (r_word_cnt != WORD_CNT_MAX)) r_word_cnt <= r_word_cnt + 5'd1;
        if (slink_cfg_dval && slink_cfg_data[ERR_BIT]) r_err <= 1'b1;
      end
    end
  end

  assign cfg_req       = r_req;
  assign cfg_busy      = r_busy;
  assign cfg_done      = r_done;
  assign cfg_req_fail  = r_fail;
  assign cfg_retry_cnt = r_retry;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_cfg_req_ctrl.sv
// Directed bench for cfg_req_ctrl: request pulses and completion flags are
// scoreboarded as events with retry count and cycle spacing.
module tb_cfg_req_ctrl;
  import cfg_pkg::*;

  localparam int W = 21;
  localparam logic [1:0] EV_REQ  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_FAIL = 2'd3;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        cfg_start = 1'b0;
  logic        slink_cfg_dval = 1'b0;
  logic [9:0]  slink_cfg_data = '0;
  logic [31:0] cfg_md_id = 32'h12345678;
  logic [7:0]  cfg_com_mode = 8'h01;
  logic        cfg_req, cfg_busy, cfg_done, cfg_req_fail;
  logic [2:0]  cfg_retry_cnt;
  cfg_state_e  dbg_state;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  cfg_req_ctrl #(.TIMEOUT_CYC(16'd100), .MAX_RETRY(3'd5), .CHECK_DLY(3'd4)) dut (
    .clk_sys        (clk_sys),
    .rst_sys        (rst_sys),
    .cfg_start      (cfg_start),
    .slink_cfg_dval (slink_cfg_dval),
    .slink_cfg_data (slink_cfg_data),
    .cfg_md_id      (cfg_md_id),
    .cfg_com_mode   (cfg_com_mode),
    .cfg_req        (cfg_req),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .cfg_req_fail   (cfg_req_fail),
    .cfg_retry_cnt  (cfg_retry_cnt),
    .dbg_state      (dbg_state)
  );

  // Clock and cycle index
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic pulse_start(input bit effective);
    cfg_start = 1'b1;
    if (effective) start_cyc = cyc;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [9:0] d);
    slink_cfg_dval = 1'b1;
    slink_cfg_data = d;
    tick(1);
    slink_cfg_dval = 1'b0;
    slink_cfg_data = '0;
  endtask

  task automatic send_frame(input int n, input int err_at);
    for (int i = 0; i < n; i++) begin
      logic [9:0] d;
      d = {2'b00, 8'(i)};
      if (i == err_at) d[9] = 1'b1;
      send_word(d);
    end
    send_word(10'h100);
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [2:0] retry, input int delta);
    exp_q.push_back({kind, retry, 16'(delta)});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},   32'(cfg_req), 32'd0);
    check({tag, "_busy"},  32'(cfg_busy), 32'd0);
    check({tag, "_done"},  32'(cfg_done), 32'd0);
    check({tag, "_fail"},  32'(cfg_req_fail), 32'd0);
    check({tag, "_retry"}, 32'(cfg_retry_cnt), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic wait_req(input string tag);
    int b = 0;
    do begin
      tick(1);
      b++;
    end while (cfg_req !== 1'b1 && b < 400);
    n_vec++;
    if (cfg_req !== 1'b1) begin
      n_err++;
      $display("FAIL %s_wait_req: no cfg_req within %0d cycles", tag, b);
    end
  endtask

  task automatic wait_end(input string tag);
    int b = 0;
    do begin
      tick(1);
      b++;
    end while (cfg_done !== 1'b1 && cfg_req_fail !== 1'b1 && b < 1000);
    n_vec++;
    if (cfg_done !== 1'b1 && cfg_req_fail !== 1'b1) begin
      n_err++;
      $display("FAIL %s_wait_end: no done/fail within %0d cycles", tag, b);
    end
  endtask

  // Scoreboard: pops one expected event for every observed DUT event
  task automatic observe(input logic [W-1:0] ev);
    logic [W-1:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: got kind=%0d retry=%0d delta=%0d, required none",
               ev[20:19], ev[18:16], ev[15:0]);
    end else begin
      e = exp_q.pop_front();
      if (ev !== e) begin
        n_err++;
        $display("FAIL event: got kind=%0d retry=%0d delta=%0d, required kind=%0d retry=%0d delta=%0d",
                 ev[20:19], ev[18:16], ev[15:0], e[20:19], e[18:16], e[15:0]);
      end
    end
  endtask

  task automatic monitor();
    logic prev_done = 1'b0;
    logic prev_fail = 1'b0;
    int   last_req = 0;
    forever begin
      @(negedge clk_sys);
      if (cfg_req === 1'b1) begin
        int ref_c;
        ref_c = (start_cyc > last_req) ? start_cyc : last_req;
        observe({EV_REQ, cfg_retry_cnt, 16'(cyc - ref_c)});
        last_req = cyc;
      end
      if (cfg_done === 1'b1 && prev_done !== 1'b1) observe({EV_DONE, cfg_retry_cnt, 16'd0});
      if (cfg_req_fail === 1'b1 && prev_fail !== 1'b1) observe({EV_FAIL, cfg_retry_cnt, 16'd0});
      prev_done = cfg_done;
      prev_fail = cfg_req_fail;
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset with cfg_start held: reset wins
    cfg_start = 1'b1;
    tick(3);
    check_idle("reset");
    rst_sys = 1'b0;
    cfg_start = 1'b0;
    tick(3);
    check_idle("post_reset");

    // Nominal frame; an error word during CHECK must be ignored
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_DONE, 3'd0, 0);
    pulse_start(1);
    wait_req("nominal");
    check("nominal_busy", 32'(cfg_busy), 32'd1);
    for (int i = 0; i < 16; i++) send_word(10'(i));
    send_word(10'h100);
    check("nominal_in_check", 32'(dbg_state), 32'(ST_CHECK));
    send_word(10'h300);
    tick(2);
    check("nominal_check_len", 32'(dbg_state), 32'(ST_CHECK));
    tick(1);
    check("nominal_done", 32'(cfg_done), 32'd1);
    check("nominal_busy_off", 32'(cfg_busy), 32'd0);
    check("nominal_retry", 32'(cfg_retry_cnt), 32'd0);

    // Short frame then good frame, restarted from DONE
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_REQ, 3'd1, 21);
    expect_ev(EV_DONE, 3'd1, 0);
    pulse_start(1);
    check("bad_done_cleared", 32'(cfg_done), 32'd0);
    wait_req("bad1");
    send_frame(15, -1);
    wait_req("bad2");
    send_frame(16, -1);
    wait_end("bad");
    check("bad_done", 32'(cfg_done), 32'd1);
    check("bad_retry", 32'(cfg_retry_cnt), 32'd1);

    // Error word, then md_id zero, then good frame
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_REQ, 3'd1, 22);
    expect_ev(EV_REQ, 3'd2, 22);
    expect_ev(EV_DONE, 3'd2, 0);
    pulse_start(1);
    wait_req("corner1");
    send_frame(16, 3);
    cfg_md_id = 32'd0;
    wait_req("corner2");
    send_frame(16, -1);
    wait_req("corner3");
    cfg_md_id = 32'h12345678;
    send_frame(16, -1);
    wait_end("corner");
    check("corner_done", 32'(cfg_done), 32'd1);
    check("corner_retry", 32'(cfg_retry_cnt), 32'd2);

    // End marker in the same cycle as the timeout
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_DONE, 3'd0, 0);
    pulse_start(1);
    wait_req("coinc");
    for (int i = 0; i < 16; i++) send_word(10'(i));
    tick(84);
    send_word(10'h100);
    check("coinc_in_check", 32'(dbg_state), 32'(ST_CHECK));
    wait_end("coinc");
    check("coinc_done", 32'(cfg_done), 32'd1);
    check("coinc_retry", 32'(cfg_retry_cnt), 32'd0);

    // No response: six requests 102 cycles apart, then failure
    expect_ev(EV_REQ, 3'd0, 2);
    for (int r = 1; r <= 5; r++) expect_ev(EV_REQ, 3'(r), 102);
    expect_ev(EV_FAIL, 3'd5, 0);
    pulse_start(1);
    wait_end("silent");
    check("silent_fail", 32'(cfg_req_fail), 32'd1);
    check("silent_done", 32'(cfg_done), 32'd0);
    check("silent_retry", 32'(cfg_retry_cnt), 32'd5);
    check("silent_busy", 32'(cfg_busy), 32'd0);
    tick(5);
    check("silent_fail_sticky", 32'(cfg_req_fail), 32'd1);
    check("silent_state", 32'(dbg_state), 32'(ST_FAIL));

    // Reset mid-WAIT after one retry: abort with no further request
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_REQ, 3'd1, 6);
    pulse_start(1);
    check("rstw_fail_cleared", 32'(cfg_req_fail), 32'd0);
    wait_req("rstw1");
    send_word(10'h100);
    wait_req("rstw2");
    send_word(10'h001);
    send_word(10'h002);
    check("rstw_retry", 32'(cfg_retry_cnt), 32'd1);
    rst_sys = 1'b1;
    tick(1);
    rst_sys = 1'b0;
    check_idle("rstw");
    tick(250);
    check("rstw_stays_idle", 32'(dbg_state), 32'(ST_IDLE));

    // cfg_start during WAIT ignored
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_DONE, 3'd0, 0);
    pulse_start(1);
    wait_req("ign");
    for (int i = 0; i < 5; i++) send_word(10'(i));
    pulse_start(0);
    for (int i = 5; i < 16; i++) send_word(10'(i));
    send_word(10'h100);
    wait_end("ign");
    check("ign_done", 32'(cfg_done), 32'd1);
    check("ign_retry", 32'(cfg_retry_cnt), 32'd0);

    // cfg_start in DONE restarts with a fresh request
    expect_ev(EV_REQ, 3'd0, 2);
    expect_ev(EV_DONE, 3'd0, 0);
    pulse_start(1);
    check("restart_done_cleared", 32'(cfg_done), 32'd0);
    check("restart_state", 32'(dbg_state), 32'(ST_REQ));
    wait_req("restart");
    send_frame(16, -1);
    wait_end("restart");
    check("restart_done", 32'(cfg_done), 32'd1);

    tick(5);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
